// File: rtl/imem_fetch_port_if.sv
// Fetch, decode-handshake and program-load signals of the instruction memory.
// The master side is the PC logic, decode stage and loader; the slave side is the memory.
interface imem_fetch_port_if #(
   parameter int XLEN = 32,
   parameter int AW   = 8
);
   logic            fetch_req;
   logic [XLEN-1:0] fetch_addr;
   logic            fetch_ready;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instruction;
   logic [1:0]      fault;
   logic            load_en;
   logic [AW-1:0]   load_addr;
   logic [7:0]      load_data;

   modport master (
      output fetch_req, fetch_addr, instr_ready, load_en, load_addr, load_data,
      input  fetch_ready, instr_valid, instruction, fault
   );

   modport slave (
      input  fetch_req, fetch_addr, instr_ready, load_en, load_addr, load_data,
      output fetch_ready, instr_valid, instruction, fault
   );
endinterface

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with a registered fetch port.
// A fetched instruction (big-endian) and its fault bits are held until decode accepts them.
// Addresses never wrap: a fetch whose last byte lies beyond the array reports out of range.
module imem_fetch_port #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 256,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   imem_fetch_port_if.slave  bus
);
   localparam int NB = XLEN / 8;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      EMPTY,
      FULL
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [1:0]      fault_q, fault_d;
   logic [7:0]      memArray_q [DEPTH];

   logic [AW-1:0]   baseAddr;
   logic [XLEN:0]   lastByteAddr;
   logic            outOfRange;
   logic            misaligned;
   logic            accept;
   logic [XLEN-1:0] rawWord;

   // The end address is one bit wider than the PC so that it can never wrap past zero.
   assign baseAddr     = bus.fetch_addr[AW-1:0];
   assign lastByteAddr = {1'b0, bus.fetch_addr} + (XLEN+1)'(NB - 1);
   assign outOfRange   = lastByteAddr >= (XLEN+1)'(DEPTH);
   assign misaligned   = ALIGN_CHECK && ((bus.fetch_addr & XLEN'(NB - 1)) != '0);

   // Gather NB consecutive bytes, lowest address into the most significant byte.
   // The low address bits only wrap for out-of-range fetches, whose data is discarded.
   for (genvar g = 0; g < NB; g++) begin : g_bytes
      logic [AW-1:0] byteAddr;
      assign byteAddr                      = baseAddr + AW'(g);
      assign rawWord[XLEN-1-8*g -: 8] = memArray_q[byteAddr];
   end

   // Load has priority, and a held result blocks new fetches until decode takes it.
   assign bus.fetch_ready = rst_n && !bus.load_en && (state_q == EMPTY || bus.instr_ready);
   assign accept          = bus.fetch_req && bus.fetch_ready;

   assign bus.instr_valid = (state_q == FULL);
   assign bus.instruction = instr_q;
   assign bus.fault       = fault_q;

   // Next state of the output register: capture on accept, drain on consume, otherwise hold.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      fault_d = fault_q;
      if (accept) begin
         state_d = FULL;
         instr_d = outOfRange ? '0 : rawWord;
         fault_d = {outOfRange, misaligned};
      end else if (state_q == FULL && bus.instr_ready) begin
         state_d = EMPTY;
      end
   end

   // Output register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         instr_q <= '0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
      end
   end

   // Program load port; the array is deliberately left untouched by reset.
   always_ff @(posedge clk) begin
      if (bus.load_en) begin
         memArray_q[bus.load_addr] <= bus.load_data;
      end
   end
endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: two instances share all stimulus,
// one with alignment checking enabled and one with it disabled.
module tb_imem_fetch_port;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   testsRun    = 0;
   int   testsFailed = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [1:0]  fault;
   } expect_t;

   expect_t expQ[$];
   expect_t expQNa[$];

   imem_fetch_port_if #(.XLEN(32), .AW(8)) bus ();
   imem_fetch_port_if #(.XLEN(32), .AW(8)) busNa ();

   imem_fetch_port #(.XLEN(32), .DEPTH(256), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   imem_fetch_port #(.XLEN(32), .DEPTH(256), .ALIGN_CHECK(1'b0)) dutNa (
      .clk(clk), .rst_n(rst_n), .bus(busNa)
   );

   assign busNa.fetch_req   = bus.fetch_req;
   assign busNa.fetch_addr  = bus.fetch_addr;
   assign busNa.instr_ready = bus.instr_ready;
   assign busNa.load_en     = bus.load_en;
   assign busNa.load_addr   = bus.load_addr;
   assign busNa.load_data   = bus.load_data;

   always #5 clk = ~clk;

   // Single comparison with failure report.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present a fetch, wait (bounded) for acceptance, and record the expected results.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expInstr,
                                input logic [1:0] expFault, input logic [1:0] expFaultNa);
      int waited;
      waited         = 0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addr;
      @(negedge clk);
      while (bus.fetch_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (bus.fetch_ready !== 1'b1) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL fetch_accept_timeout: addr 0x%0h never accepted", addr);
      end else begin
         expQ.push_back('{instr: expInstr, fault: expFault});
         expQNa.push_back('{instr: expInstr, fault: expFaultNa});
      end
      @(posedge clk);
      #1;
      bus.fetch_req = 1'b0;
   endtask

   task automatic loadByte(input logic [7:0] addr, input logic [7:0] data);
      bus.load_en   = 1'b1;
      bus.load_addr = addr;
      bus.load_data = data;
      @(posedge clk);
      #1;
      bus.load_en = 1'b0;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the alignment-checking instance: every valid cycle must match the queue head.
   always @(negedge clk) begin
      if (bus.instr_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_result: instruction 0x%0h with nothing expected", bus.instruction);
         end else begin
            checkOutput("instruction", 64'(bus.instruction), 64'(expQ[0].instr));
            checkOutput("fault", 64'(bus.fault), 64'(expQ[0].fault));
            if (bus.instr_ready === 1'b1) expQ.delete(0);
         end
      end
   end

   // Monitor for the instance without alignment checking.
   always @(negedge clk) begin
      if (busNa.instr_valid === 1'b1) begin
         if (expQNa.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_result_noalign: instruction 0x%0h with nothing expected", busNa.instruction);
         end else begin
            checkOutput("instruction_noalign", 64'(busNa.instruction), 64'(expQNa[0].instr));
            checkOutput("fault_noalign", 64'(busNa.fault), 64'(expQNa[0].fault));
            if (busNa.instr_ready === 1'b1) expQNa.delete(0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] prog [8];
      logic [7:0] top4 [4];
      logic [7:0] mid4 [4];
      prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      top4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      mid4 = '{8'h01, 8'h02, 8'h03, 8'h04};

      bus.fetch_req   = 1'b0;
      bus.fetch_addr  = '0;
      bus.instr_ready = 1'b1;
      bus.load_en     = 1'b0;
      bus.load_addr   = '0;
      bus.load_data   = '0;
      rst_n           = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_valid", 64'(bus.instr_valid), 64'd0);
      checkOutput("reset_instruction", 64'(bus.instruction), 64'd0);
      checkOutput("reset_fault", 64'(bus.fault), 64'd0);
      checkOutput("reset_fetch_ready", 64'(bus.fetch_ready), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("release_valid", 64'(bus.instr_valid), 64'd0);
      checkOutput("release_fetch_ready", 64'(bus.fetch_ready), 64'd1);
      idleCycle();

      // Program load
      for (int i = 0; i < 8; i++) loadByte(8'(i), prog[i]);
      for (int i = 0; i < 4; i++) loadByte(8'(8 + i), mid4[i]);
      for (int i = 0; i < 4; i++) loadByte(8'(252 + i), top4[i]);

      // Back-to-back aligned fetches
      applyStimulus(32'd0, 32'h11223344, 2'b00, 2'b00);
      applyStimulus(32'd4, 32'h55667788, 2'b00, 2'b00);
      // Misaligned but in range
      applyStimulus(32'd2, 32'h33445566, 2'b01, 2'b00);
      // Range boundaries, including a PC near 2^32 that must not wrap
      applyStimulus(32'd252, 32'hA1B2C3D4, 2'b00, 2'b00);
      applyStimulus(32'd253, 32'h00000000, 2'b11, 2'b10);
      applyStimulus(32'h100, 32'h00000000, 2'b10, 2'b10);
      applyStimulus(32'hFFFF_FFFE, 32'h00000000, 2'b11, 2'b10);
      idleCycle();

      // Backpressure: result held while decode stalls
      bus.instr_ready = 1'b0;
      applyStimulus(32'd0, 32'h11223344, 2'b00, 2'b00);
      repeat (3) begin
         @(negedge clk);
         checkOutput("fetch_ready_stalled", 64'(bus.fetch_ready), 64'd0);
         checkOutput("valid_stalled", 64'(bus.instr_valid), 64'd1);
      end
      idleCycle();
      bus.instr_ready = 1'b1;
      applyStimulus(32'd4, 32'h55667788, 2'b00, 2'b00);
      idleCycle();

      // Load and fetch in the same cycle: load wins, fetch sees the new byte afterwards
      bus.load_en    = 1'b1;
      bus.load_addr  = 8'd8;
      bus.load_data  = 8'h9A;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'd8;
      @(negedge clk);
      checkOutput("fetch_ready_during_load", 64'(bus.fetch_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.load_en = 1'b0;
      applyStimulus(32'd8, 32'h9A020304, 2'b00, 2'b00);
      idleCycle();

      // Reset while a result is held
      bus.instr_ready = 1'b0;
      applyStimulus(32'd4, 32'h55667788, 2'b00, 2'b00);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("fetch_ready_in_reset", 64'(bus.fetch_ready), 64'd0);
      @(posedge clk);
      #1;
      expQ.delete();
      expQNa.delete();
      @(negedge clk);
      checkOutput("midreset_valid", 64'(bus.instr_valid), 64'd0);
      checkOutput("midreset_instruction", 64'(bus.instruction), 64'd0);
      checkOutput("midreset_fault", 64'(bus.fault), 64'd0);
      checkOutput("midreset_valid_noalign", 64'(busNa.instr_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n           = 1'b1;
      bus.instr_ready = 1'b1;

      // Memory contents survive reset
      applyStimulus(32'd0, 32'h11223344, 2'b00, 2'b00);
      applyStimulus(32'd252, 32'hA1B2C3D4, 2'b00, 2'b00);
      idleCycle();
      idleCycle();
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      checkOutput("queue_drained_noalign", 64'(expQNa.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
